seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Runtime-programmable serial bit-pattern detector, successor to the fixed 5-state "10110" detector.
//  Pattern, length (1..MAX_LEN) and overlap mode are loaded at runtime.
//  Emits a registered match pulse and keeps a saturating match counter.
//  Sits on a serial qualified-bit stream (x/x_valid); match and match_count feed status/interrupt logic.
// PARAMETERS
//  MAX_LEN      16              longest supported pattern, in bits (>=2)
//  CNT_W        8               match_count width
//  DEF_PATTERN  16'b1_0110      reset pattern, LSB-aligned
//  DEF_LEN      5               reset pattern length
//  DEF_OVERLAP  1               reset overlap mode
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  x            in   1          serial data bit
//  x_valid      in   1          x is accepted on this clk edge
//  cfg_load     in   1          pulse: latch cfg_* into active config
//  cfg_pattern  in   MAX_LEN    pattern; bit[len-1] = first bit received, bit[0] = last
//  cfg_len      in   LW         pattern length; LW = $clog2(MAX_LEN+1)
//  cfg_overlap  in   1          1 = overlapping matches allowed; 0 = restart after a match
//  count_clr    in   1          pulse: clear match_count
//  match        out  1          one-cycle pulse, registered
//  match_count  out  CNT_W      saturating count of matches
//  cfg_err      out  1          active cfg_len is 0 or >MAX_LEN; detector disabled
// BEHAVIOUR
//  Reset (async) values:
//   - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP
//   - hist=0, fill=0, match=0, match_count=0, cfg_err=0
//  State:
//   - hist[MAX_LEN-1:0]: shift register of received bits
//   - fill: number of valid history bits, range 0..MAX_LEN, saturating
//  Accept (x_valid=1, cfg_load=0):
//   - hist <= {hist[MAX_LEN-2:0], x}
//   - fill <= min(fill+1, MAX_LEN)
//  Hit: (fill+1 >= len) AND the low len bits of the new hist equal pattern[len-1:0] AND cfg_err=0.
//  Match timing:
//   - match=1 on the edge that accepts the completing bit, visible the cycle after the bit was presented.
//   - match=0 in every other cycle.
//   - Fixed latency of 1 cycle, one pulse per hit.
//  Overlap mode:
//   - overlap=1: history is kept after a hit (10101 with pattern 101 -> 2 hits).
//   - overlap=0: a hit forces fill <= 0, so the next hit needs len fresh bits.
//  x_valid=0: no shift, no fill change, match=0. Idle gaps of any length are transparent.
//  cfg_load:
//   - Latches pattern/len/overlap; clears hist and fill; match=0 that cycle.
//   - x_valid in the same cycle is ignored (the bit is dropped).
//   - match_count is not affected.
//  cfg_err:
//   - Registered from the latched len: 1 iff len==0 or len>MAX_LEN.
//   - While cfg_err=1, no hits occur; bits still shift.
//  match_count:
//   - +1 per hit; saturates at 2^CNT_W-1, no wrap.
//   - count_clr alone -> 0.
//   - count_clr together with a hit -> 1; the hit is not lost.
//  len==1: every accepted bit equal to pattern[0] is a hit; overlap mode is irrelevant.
//  len==MAX_LEN: compare all of hist; a hit requires fill to reach MAX_LEN.
//  Reset mid-stream: partial progress is lost; a pending match is cleared immediately.
// TESTING
//  T1 defaults: reset, x_valid bits 1,0,1,1,0
//     -> match=1 only in the cycle after bit 5; match_count=1.
//  T2 overlap: load pattern 101, len 3, overlap=1; feed 1,0,1,0,1
//     -> hits after bits 3 and 5, count=2.
//     Repeat with overlap=0 -> one hit (bit 3), count=1.
//  T3 gaps: T1 stream with 0-3 random idle cycles between bits
//     -> identical single hit, no extra pulses.
//  T4 saturation: CNT_W=4, len 1, pattern 1, feed 20 ones
//     -> count stops at 15.
//     Then count_clr together with a hit -> count=1.
//  T5 config edges:
//     - cfg_len=0 -> cfg_err=1 next cycle; 32 random bits give no match.
//     - Load len=MAX_LEN, all-ones pattern; feed MAX_LEN ones -> hit only on bit MAX_LEN.
//     - cfg_load with x_valid in the same cycle -> that bit is dropped.
//  T6 reset mid-op: feed 1,0,1,1; assert rst; release; feed 0
//     -> no match; the full 10110 is then needed again.

Source files
------------

// File: rtl/seq_det_prog_if.sv
// Bus bundle for the programmable serial pattern detector: bit stream,
// runtime configuration, counter clear and status outputs.
interface seq_det_prog_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int LW      = $clog2(MAX_LEN + 1)
);
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        input  match, match_count, cfg_err
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
        output match, match_count, cfg_err
    );
endinterface

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// registered one-cycle match pulse and saturating match counter.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 16,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(5'b1_0110),
    parameter int                 DEF_LEN     = 5,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_prog_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Mask selecting the low len bits of the history.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] pattern_r;
    logic [LW-1:0]      len_r;
    logic               overlap_r;
    logic               cfg_err_r;
    // The oldest history bit is never compared after a shift, so only
    // MAX_LEN-1 bits are kept; the new bit completes the window.
    logic [MAX_LEN-2:0] hist_r;
    logic [LW-1:0]      fill_r;
    logic               match_r;
    logic [CNT_W-1:0]   count_r;

    logic               accept_s;
    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LW:0]        fill_inc_s;
    logic               hit_s;
    logic [MAX_LEN-2:0] hist_d_s;
    logic [LW-1:0]      fill_d_s;
    logic [CNT_W-1:0]   count_d_s;
    logic               cfg_err_d_s;

    // Hit detection on the window formed by the incoming bit.
    always_comb begin
        accept_s   = bus.x_valid & ~bus.cfg_load;
        window_s   = {hist_r, bus.x};
        mask_s     = len_mask(len_r);
        fill_inc_s = {1'b0, fill_r} + (LW+1)'(1);
        hit_s      = accept_s & ~cfg_err_r
                   & (fill_inc_s >= {1'b0, len_r})
                   & ((window_s & mask_s) == (pattern_r & mask_s));
        cfg_err_d_s = (bus.cfg_len == LW'(0)) | (bus.cfg_len > LW'(MAX_LEN));
    end

    // Next history, fill level and match counter.
    always_comb begin
        hist_d_s  = hist_r;
        fill_d_s  = fill_r;
        count_d_s = count_r;
        if (bus.cfg_load) begin
            hist_d_s = '0;
            fill_d_s = '0;
        end else if (accept_s) begin
            hist_d_s = window_s[MAX_LEN-2:0];
            if (hit_s && !overlap_r) begin
                fill_d_s = '0;
            end else if (fill_inc_s > (LW+1)'(MAX_LEN)) begin
                fill_d_s = fill_r;
            end else begin
                fill_d_s = fill_inc_s[LW-1:0];
            end
        end else begin
            hist_d_s = hist_r;
            fill_d_s = fill_r;
        end
        if (bus.count_clr) begin
            count_d_s = hit_s ? CNT_W'(1) : CNT_W'(0);
        end else if (hit_s && (count_r != CNT_MAX)) begin
            count_d_s = count_r + CNT_W'(1);
        end else begin
            count_d_s = count_r;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r <= DEF_PATTERN;
            len_r     <= LW'(DEF_LEN);
            overlap_r <= DEF_OVERLAP;
            cfg_err_r <= 1'b0;
            hist_r    <= '0;
            fill_r    <= '0;
            match_r   <= 1'b0;
            count_r   <= '0;
        end else begin
            hist_r  <= hist_d_s;
            fill_r  <= fill_d_s;
            match_r <= hit_s;
            count_r <= count_d_s;
            if (bus.cfg_load) begin
                pattern_r <= bus.cfg_pattern;
                len_r     <= bus.cfg_len;
                overlap_r <= bus.cfg_overlap;
                cfg_err_r <= cfg_err_d_s;
            end else begin
                pattern_r <= pattern_r;
                len_r     <= len_r;
                overlap_r <= overlap_r;
                cfg_err_r <= cfg_err_r;
            end
        end
    end

    assign bus.match       = match_r;
    assign bus.match_count = count_r;
    assign bus.cfg_err     = cfg_err_r;
endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_seq_det_prog;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 4;
    localparam int LW      = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dif ();
    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(dif));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: accepted bits since the last restart, newest at the back.
    int                 q[$];
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_err;
    bit                 exp_match;
    int                 exp_cnt;
    bit                 exp_err;
    int                 hits;
    int                 bitno;
    int                 last_hit;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pat     = 16'b1_0110;
        m_len     = 5;
        m_ovl     = 1'b1;
        m_err     = 1'b0;
        exp_match = 1'b0;
        exp_cnt   = 0;
        exp_err   = 1'b0;
    endtask

    task automatic begin_test();
        hits     = 0;
        bitno    = 0;
        last_hit = 0;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        check("match", int'(dif.match), int'(exp_match));
        check("match_count", int'(dif.match_count), exp_cnt);
        check("cfg_err", int'(dif.cfg_err), int'(exp_err));
    end

    task automatic step(input bit v, input bit b, input bit ld, input bit clr);
        bit hit;
        bit ok;
        dif.x_valid   = v;
        dif.x         = b;
        dif.cfg_load  = ld;
        dif.count_clr = clr;
        @(posedge clk);
        hit = 1'b0;
        if (ld) begin
            m_pat = dif.cfg_pattern;
            m_len = int'(dif.cfg_len);
            m_ovl = dif.cfg_overlap;
            m_err = (m_len == 0) || (m_len > MAX_LEN);
            q.delete();
        end else if (v) begin
            bitno++;
            q.push_back(int'(b));
            if (q.size() > MAX_LEN) void'(q.pop_front());
            if (!m_err && q.size() >= m_len) begin
                ok = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (q[q.size() - m_len + i] != int'(m_pat[m_len - 1 - i])) ok = 1'b0;
                end
                hit = ok;
            end
            if (hit && !m_ovl) q.delete();
        end
        exp_match = hit;
        if (clr) exp_cnt = hit ? 1 : 0;
        else if (hit && exp_cnt < CNT_MAX) exp_cnt++;
        exp_err = m_err;
        if (hit) begin
            hits++;
            last_hit = bitno;
        end
        #1;
        dif.x_valid   = 1'b0;
        dif.cfg_load  = 1'b0;
        dif.count_clr = 1'b0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                        input bit ovl, input bit v, input bit b);
        dif.cfg_pattern = pat;
        dif.cfg_len     = len;
        dif.cfg_overlap = ovl;
        step(v, b, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_match_now", int'(dif.match), 0);
        check("rst_count_now", int'(dif.match_count), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] t1;
        rst             = 1'b1;
        dif.x           = 1'b0;
        dif.x_valid     = 1'b0;
        dif.cfg_load    = 1'b0;
        dif.cfg_pattern = '0;
        dif.cfg_len     = '0;
        dif.cfg_overlap = 1'b0;
        dif.count_clr   = 1'b0;
        model_reset();
        begin_test();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        check("reset_match", int'(dif.match), 0);
        check("reset_count", int'(dif.match_count), 0);
        check("reset_cfg_err", int'(dif.cfg_err), 0);

        // T1: default pattern 10110
        begin_test();
        feed(32'b10110, 5);
        check("t1_hits", hits, 1);
        check("t1_hit_bit", last_hit, 5);
        check("t1_count", int'(dif.match_count), 1);

        // T2: pattern 101, overlapping then restart mode
        load(16'b101, 5'd3, 1'b1, 1'b0, 1'b0);
        begin_test();
        feed(32'b10101, 5);
        check("t2_ovl_hits", hits, 2);
        check("t2_ovl_count", int'(dif.match_count), 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_clr", int'(dif.match_count), 0);
        load(16'b101, 5'd3, 1'b0, 1'b0, 1'b0);
        begin_test();
        feed(32'b10101, 5);
        check("t2_noovl_hits", hits, 1);
        check("t2_noovl_bit", last_hit, 3);
        check("t2_noovl_count", int'(dif.match_count), 1);

        // T3: default stream with random idle gaps
        load(16'b1_0110, 5'd5, 1'b1, 1'b0, 1'b0);
        begin_test();
        t1 = 32'b10110;
        for (int i = 4; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            step(1'b1, t1[i], 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_hits", hits, 1);
        check("t3_hit_bit", last_hit, 5);

        // T4: counter saturation and clear-with-hit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        load(16'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        begin_test();
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_hits", hits, 20);
        check("t4_saturated", int'(dif.match_count), 15);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("t4_clr_with_hit", int'(dif.match_count), 1);

        // T5: invalid lengths, full-length pattern, load drops a bit
        load(16'h0000, 5'd0, 1'b1, 1'b0, 1'b0);
        check("t5_err_len0", int'(dif.cfg_err), 1);
        begin_test();
        repeat (32) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t5_err_hits", hits, 0);
        load(16'hFFFF, 5'd20, 1'b1, 1'b0, 1'b0);
        check("t5_err_len20", int'(dif.cfg_err), 1);
        load(16'hFFFF, 5'd16, 1'b1, 1'b0, 1'b0);
        check("t5_err_cleared", int'(dif.cfg_err), 0);
        begin_test();
        repeat (16) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_full_hits", hits, 1);
        check("t5_full_bit", last_hit, 16);
        load(16'b101, 5'd3, 1'b1, 1'b1, 1'b1);
        begin_test();
        feed(32'b0101, 4);
        check("t5_drop_hits", hits, 1);
        check("t5_drop_bit", last_hit, 4);

        // T6: reset mid-stream, then reset with a pending match
        load(16'b1_0110, 5'd5, 1'b1, 1'b0, 1'b0);
        feed(32'b1011, 4);
        do_reset();
        begin_test();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_no_match", int'(dif.match), 0);
        feed(32'b10110, 5);
        check("t6_hits", hits, 1);
        check("t6_hit_bit", last_hit, 6);
        check("t6_pending", int'(dif.match), 1);
        do_reset();
        check("t6_pending_cleared", int'(dif.match), 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
